// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment loop-back decoder: active-low glyph
// table (g..a), blank codes, and small helpers usable by RTL and bench models.
package seg_scan_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_BLANK  = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Index n holds the glyph for nibble n.
  localparam logic [15:0][6:0] GLYPH_TBL = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    return GLYPH_TBL[n];
  endfunction

  function automatic logic an_onehot_low(input logic [3:0] an);
    return $onehot(~an);
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational active-low seven-segment glyph to hex nibble decoder.
module seg_glyph_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] glyph_i,
  output logic       ok_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    ok_o     = 1'b0;
    nibble_o = 4'h0;
    for (int i = 0; i < 16; i++) begin
      if (glyph_i == GLYPH_TBL[i]) begin
        ok_o     = 1'b1;
        nibble_o = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed active-low seven-segment bus, debounces each digit
// dwell, and reassembles the 16-bit displayed value with error flags.
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  segment,
  input  logic [3:0]  AN,
  output logic [15:0] value,
  output logic        valid,
  output logic [3:0]  digit_mask,
  output logic        seg_err,
  output logic        an_err
);

  localparam int            SW       = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_C = SW'(SETTLE);

  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic [SW-1:0]   stab_q, stab_d;
  logic            captured_q, captured_d;
  logic [3:0][3:0] shadow_q, shadow_d;
  logic [3:0]      mask_q, mask_d;
  logic [15:0]     value_q, value_d;
  logic            valid_q, valid_d, seg_err_q, seg_err_d, an_err_q, an_err_d;
  logic            chg, stable, glyph_ok;
  logic [3:0]      nib;
  logic [1:0]      dig;

  seg_glyph_decode u_dec (
    .glyph_i (seg_q),
    .ok_o    (glyph_ok),
    .nibble_o(nib)
  );

  always_comb begin
    dig = 2'd0;
    case (an_q)
      4'b1101: dig = 2'd1;
      4'b1011: dig = 2'd2;
      4'b0111: dig = 2'd3;
      default: dig = 2'd0;
    endcase
  end

  always_comb begin
    // A change is seen on the edge that loads the new pair, so the count
    // restarts together with the input register and capture lands on E+SETTLE.
    chg        = {AN, segment} != {an_q, seg_q};
    stab_d     = chg ? '0 : ((stab_q == SETTLE_C) ? stab_q : stab_q + 1'b1);
    stable     = !chg && !captured_q && (stab_d == SETTLE_C);
    captured_d = !chg && (captured_q || stable);
    shadow_d   = shadow_q;
    mask_d     = mask_q;
    value_d    = value_q;
    valid_d    = 1'b0;
    seg_err_d  = 1'b0;
    an_err_d   = 1'b0;
    if (stable && an_q != AN_BLANK) begin
      if (!an_onehot_low(an_q)) begin
        an_err_d = 1'b1;
        mask_d   = 4'h0;
      end else if (!glyph_ok) begin
        seg_err_d = 1'b1;
        mask_d    = 4'h0;
      end else begin
        shadow_d[dig] = nib;
        mask_d        = mask_q | (4'b0001 << dig);
        if (mask_d == 4'hF) begin
          value_d = shadow_d;
          valid_d = 1'b1;
          mask_d  = 4'h0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q       <= AN_BLANK;
      seg_q      <= SEG_BLANK;
      stab_q     <= '0;
      captured_q <= 1'b0;
      shadow_q   <= '0;
      mask_q     <= 4'h0;
      value_q    <= 16'h0;
      valid_q    <= 1'b0;
      seg_err_q  <= 1'b0;
      an_err_q   <= 1'b0;
    end else begin
      an_q       <= AN;
      seg_q      <= segment;
      stab_q     <= stab_d;
      captured_q <= captured_d;
      shadow_q   <= shadow_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      seg_err_q  <= seg_err_d;
      an_err_q   <= an_err_d;
    end
  end

  assign value      = value_q;
  assign valid      = valid_q;
  assign digit_mask = mask_q;
  assign seg_err    = seg_err_q;
  assign an_err     = an_err_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scoreboard bench: stimulus queues expected output events, a
// negedge monitor pops and compares each valid/seg_err/an_err pulse.
module tb_seg_scan_decoder;
  import seg_scan_pkg::*;

  localparam int K_VALID = 1, K_SEGERR = 2, K_ANERR = 3;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  segment;
  logic [3:0]  AN;
  logic [15:0] value;
  logic        valid, seg_err, an_err;
  logic [3:0]  digit_mask;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  seg_scan_decoder #(.SETTLE(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .segment   (segment),
    .AN        (AN),
    .value     (value),
    .valid     (valid),
    .digit_mask(digit_mask),
    .seg_err   (seg_err),
    .an_err    (an_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] v);
    exp_t e;
    e.kind = kind;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic check_ev(input int kind, input logic [15:0] v);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d value %0h expected no event", kind, v);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == K_VALID && e.val !== v)) begin
        fails++;
        $display("FAIL event: got kind %0d value %0h expected kind %0d value %0h",
                 kind, v, e.kind, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid)   check_ev(K_VALID, value);
      if (seg_err) check_ev(K_SEGERR, 16'h0);
      if (an_err)  check_ev(K_ANERR, 16'h0);
    end
  end

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    AN      = an;
    segment = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dig(input int k, input logic [3:0] n, input int cyc);
    logic [3:0] sel;
    sel = 4'b0001 << k;
    hold(~sel, glyph_of(n), cyc);
  endtask

  task automatic frame(input logic [15:0] v);
    expect_ev(K_VALID, v);
    for (int k = 0; k < 4; k++) dig(k, v[4*k +: 4], 8);
  endtask

  initial begin
    rst_n   = 1'b0;
    AN      = AN_BLANK;
    segment = SEG_BLANK;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", value, 16'h0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_mask", digit_mask, 4'h0);
    chk("rst_seg_err", seg_err, 1'b0);
    chk("rst_an_err", an_err, 1'b0);
    rst_n = 1'b1;
    hold(AN_BLANK, SEG_BLANK, 6);

    // Clean scan with capture-latency probe on digit 0
    expect_ev(K_VALID, 16'h1A2F);
    AN = 4'hE;
    segment = glyph_of(4'hF);
    repeat (4) @(posedge clk);
    #1 chk("latency_before", digit_mask, 4'h0);
    @(posedge clk);
    #1 chk("latency_at", digit_mask, 4'h1);
    repeat (3) @(posedge clk);
    #1;
    dig(1, 4'h2, 8);
    chk("mask_two", digit_mask, 4'h3);
    dig(2, 4'hA, 8);
    dig(3, 4'h1, 8);
    chk("clean_mask_clear", digit_mask, 4'h0);
    chk("clean_value", value, 16'h1A2F);

    // Glitch rejection: short wrong glyph on digit 1
    expect_ev(K_VALID, 16'h1A2F);
    dig(0, 4'hF, 8);
    hold(4'hD, 7'h00, 2);
    chk("glitch_no_capture", digit_mask, 4'h1);
    dig(1, 4'h2, 8);
    dig(2, 4'hA, 8);
    dig(3, 4'h1, 8);

    // Invalid glyph on digit 2
    dig(0, 4'h3, 8);
    dig(1, 4'h4, 8);
    expect_ev(K_SEGERR, 16'h0);
    hold(4'hB, SEG_BLANK, 8);
    chk("seg_err_mask", digit_mask, 4'h0);
    dig(3, 4'h6, 8);
    chk("after_seg_err_mask", digit_mask, 4'h8);
    chk("no_frame_value", value, 16'h1A2F);

    // Bad AN, then blank AN leaves state alone
    expect_ev(K_ANERR, 16'h0);
    hold(4'b1100, glyph_of(4'h5), 8);
    chk("an_err_mask", digit_mask, 4'h0);
    dig(0, 4'h7, 8);
    hold(AN_BLANK, glyph_of(4'h8), 8);
    hold(AN_BLANK, SEG_BLANK, 8);
    chk("blank_mask", digit_mask, 4'h1);

    // Reset mid-frame
    dig(0, 4'hF, 8);
    dig(1, 4'hF, 8);
    dig(2, 4'hF, 8);
    chk("pre_reset_mask", digit_mask, 4'h7);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_value", value, 16'h0);
    chk("mid_rst_mask", digit_mask, 4'h0);
    chk("mid_rst_flags", {valid, seg_err, an_err}, 3'b000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    frame(16'h0000);

    // Repeat capture of digit 0 overwrites without error
    expect_ev(K_VALID, 16'h1975);
    dig(0, 4'h3, 8);
    dig(0, 4'h5, 8);
    chk("repeat_mask", digit_mask, 4'h1);
    dig(1, 4'h7, 8);
    dig(2, 4'h9, 8);
    dig(3, 4'h1, 8);
    chk("repeat_value", value, 16'h1975);
    hold(AN_BLANK, SEG_BLANK, 8);

    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
